// File: rtl/cache_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter_if
// Groups the icache/dcache refill handshakes and the shared memory port that
// the cache_mem_arbiter serialises.
//   slave  : the arbiter's view (cache requests and memory responses in;
//            grants, memory strobes and line returns out)
//   master : the environment's view (caches plus memory model / bus bridge)
// Signal groups:
//   ic_*      icache line read request and line return
//   dc_rd_*   dcache line read request and accept
//   dc_wr_*   dcache word write request and accept
//   dc_ret_*  dcache line return
//   mem_*     single shared memory read/write channel
// ---------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              ic_rd_req;
  logic [ADDR_W-1:0] ic_rd_addr;
  logic              ic_ret_valid;
  logic [LINE_W-1:0] ic_ret_data;

  logic              dc_rd_req;
  logic [ADDR_W-1:0] dc_rd_addr;
  logic              dc_rd_rdy;

  logic              dc_wr_req;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [3:0]        dc_wr_wstrb;
  logic [31:0]       dc_wr_data;
  logic              dc_wr_rdy;

  logic              dc_ret_valid;
  logic [LINE_W-1:0] dc_ret_data;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [LINE_W-1:0] mem_rd_data;
  logic              mem_rd_valid;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wr_data;
  logic              mem_wr_ack;

  modport slave (
    input  ic_rd_req, ic_rd_addr,
    output ic_ret_valid, ic_ret_data,
    input  dc_rd_req, dc_rd_addr,
    output dc_rd_rdy,
    input  dc_wr_req, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
    output dc_wr_rdy,
    output dc_ret_valid, dc_ret_data,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data, mem_rd_valid,
    output mem_wr_en, mem_wr_addr, mem_wstrb, mem_wr_data,
    input  mem_wr_ack
  );

  modport master (
    output ic_rd_req, ic_rd_addr,
    input  ic_ret_valid, ic_ret_data,
    output dc_rd_req, dc_rd_addr,
    input  dc_rd_rdy,
    output dc_wr_req, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
    input  dc_wr_rdy,
    input  dc_ret_valid, dc_ret_data,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data, mem_rd_valid,
    input  mem_wr_en, mem_wr_addr, mem_wstrb, mem_wr_data,
    output mem_wr_ack
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
// Serialises icache line reads, dcache line reads and dcache word writes onto
// one shared memory channel and routes the returned line to the requester.
// Priority is dcache write > dcache read > icache read, except that once the
// icache has watched STARVE_LIMIT dcache grants go by while it was waiting,
// it wins the next arbitration.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  cache_mem_arbiter_if.slave (cache requests, line returns, memory port)
// Grants (rdy/en and the granted address) are combinational in the IDLE
// cycle; write payload and read address are captured and held afterwards.
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_mem_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_WAIT  = 2'd1,
    IRD_WAIT = 2'd2,
    DRD_WAIT = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic              gap_r;        // read just finished: keep IDLE one cycle
  logic              ic_flush_r;   // icache dropped its request mid-read

  logic [ADDR_W-1:0] rd_addr_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [3:0]        wstrb_r;
  logic [31:0]       wr_data_r;

  logic              ic_ret_valid_r;
  logic              dc_ret_valid_r;
  logic [LINE_W-1:0] ic_ret_data_r;
  logic [LINE_W-1:0] dc_ret_data_r;

  logic              gnt_wr_s;
  logic              gnt_drd_s;
  logic              gnt_ird_s;
  logic              ic_force_s;

  // Next-state and IDLE arbitration
  always_comb begin
    state_nxt_s = state_r;
    gnt_wr_s    = 1'b0;
    gnt_drd_s   = 1'b0;
    gnt_ird_s   = 1'b0;
    ic_force_s  = bus.ic_rd_req && (starve_cnt_r == CNT_W'(STARVE_LIMIT));
    case (state_r)
      IDLE: begin
        if (rst || gap_r) begin
          state_nxt_s = IDLE;
        end else if (ic_force_s) begin
          gnt_ird_s   = 1'b1;
          state_nxt_s = IRD_WAIT;
        end else if (bus.dc_wr_req) begin
          gnt_wr_s    = 1'b1;
          state_nxt_s = WR_WAIT;
        end else if (bus.dc_rd_req) begin
          gnt_drd_s   = 1'b1;
          state_nxt_s = DRD_WAIT;
        end else if (bus.ic_rd_req) begin
          gnt_ird_s   = 1'b1;
          state_nxt_s = IRD_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR_WAIT: begin
        if (bus.mem_wr_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WR_WAIT;
        end
      end
      IRD_WAIT: begin
        if (bus.mem_rd_valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = IRD_WAIT;
        end
      end
      DRD_WAIT: begin
        if (bus.mem_rd_valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRD_WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, capture registers, return pulses and starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      starve_cnt_r   <= '0;
      gap_r          <= 1'b0;
      ic_flush_r     <= 1'b0;
      rd_addr_r      <= '0;
      wr_addr_r      <= '0;
      wstrb_r        <= 4'd0;
      wr_data_r      <= 32'd0;
      ic_ret_valid_r <= 1'b0;
      dc_ret_valid_r <= 1'b0;
      ic_ret_data_r  <= '0;
      dc_ret_data_r  <= '0;
    end else begin
      state_r        <= state_nxt_s;
      ic_ret_valid_r <= 1'b0;
      dc_ret_valid_r <= 1'b0;
      gap_r          <= 1'b0;

      if (gnt_wr_s) begin
        wr_addr_r <= bus.dc_wr_addr;
        wstrb_r   <= bus.dc_wr_wstrb;
        wr_data_r <= bus.dc_wr_data;
      end

      if (gnt_drd_s) begin
        rd_addr_r <= bus.dc_rd_addr;
      end else if (gnt_ird_s) begin
        rd_addr_r <= bus.ic_rd_addr;
      end

      // Counts dcache wins the waiting icache has watched; saturates
      if (gnt_ird_s) begin
        starve_cnt_r <= '0;
      end else if ((gnt_wr_s || gnt_drd_s) && bus.ic_rd_req) begin
        if (starve_cnt_r != CNT_W'(STARVE_LIMIT)) begin
          starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end
      end else if ((state_r == IDLE) && !bus.ic_rd_req) begin
        starve_cnt_r <= '0;
      end

      case (state_r)
        IDLE: begin
          ic_flush_r <= 1'b0;
        end
        IRD_WAIT: begin
          // A flushed fetch still completes with memory but is not returned
          if (!bus.ic_rd_req) begin
            ic_flush_r <= 1'b1;
          end
          if (bus.mem_rd_valid) begin
            gap_r <= 1'b1;
            if (bus.ic_rd_req && !ic_flush_r) begin
              ic_ret_valid_r <= 1'b1;
              ic_ret_data_r  <= bus.mem_rd_data;
            end
          end
        end
        DRD_WAIT: begin
          if (bus.mem_rd_valid) begin
            gap_r          <= 1'b1;
            dc_ret_valid_r <= 1'b1;
            dc_ret_data_r  <= bus.mem_rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.dc_wr_rdy    = gnt_wr_s;
  assign bus.mem_wr_en    = gnt_wr_s;
  assign bus.dc_rd_rdy    = gnt_drd_s;
  assign bus.mem_rd_en    = gnt_drd_s | gnt_ird_s;

  // Granted request is forwarded in the grant cycle, then held from capture
  assign bus.mem_rd_addr  = gnt_drd_s ? bus.dc_rd_addr :
                            (gnt_ird_s ? bus.ic_rd_addr : rd_addr_r);
  assign bus.mem_wr_addr  = gnt_wr_s ? bus.dc_wr_addr  : wr_addr_r;
  assign bus.mem_wstrb    = gnt_wr_s ? bus.dc_wr_wstrb : wstrb_r;
  assign bus.mem_wr_data  = gnt_wr_s ? bus.dc_wr_data  : wr_data_r;

  assign bus.ic_ret_valid = ic_ret_valid_r;
  assign bus.ic_ret_data  = ic_ret_data_r;
  assign bus.dc_ret_valid = dc_ret_valid_r;
  assign bus.dc_ret_data  = dc_ret_data_r;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Scoreboard bench: each request pushes its expected memory grant and, when
// a line return is due, its expected line data. A negedge process plays the
// memory, checks grants and returns against the queues, and enforces the
// interlocks (single outstanding transaction, exclusive strobes/rdy).
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;

  localparam int ADDR_W       = 32;
  localparam int LINE_W       = 256;
  localparam int STARVE_LIMIT = 4;

  localparam logic [1:0] K_WR = 2'd0;
  localparam logic [1:0] K_DR = 2'd1;
  localparam logic [1:0] K_IR = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } gnt_t;

  logic clk;
  logic rst;

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus();

  cache_mem_arbiter #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  gnt_t         gnt_q[$];
  logic [255:0] ic_q[$];
  logic [255:0] dc_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_delay;
  int wr_delay;
  int inject_cyc;
  bit rd_resp_en;

  // memory-model state (written only by the negedge process)
  bit busy           = 1'b0;
  int free_cyc       = -1;
  int last_valid_cyc = -10;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (a == 32'h1C00_0040) return {32{8'hAA}};
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1, {a[15:0], a[31:16]},
            a ^ 32'hFFFF_0000, a - 32'd7, 32'hC0DE_0000 | a};
  endfunction

  function automatic gnt_t mk(input logic [1:0] k, input logic [31:0] a,
                              input logic [3:0] s, input logic [31:0] d);
    gnt_t g;
    g.kind = k; g.addr = a; g.strb = s; g.data = d;
    return g;
  endfunction

  // Memory model + output monitor, all at negedge
  initial begin : mem_model
    gnt_t g;
    logic [1:0]  kind_obs;
    logic [31:0] rd_addr_m;
    int rd_cnt;
    int wr_cnt;
    rd_cnt = 0;
    wr_cnt = 0;
    rd_addr_m = 32'd0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    bus.mem_wr_ack   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_rd_en || bus.mem_wr_en || bus.dc_rd_rdy || bus.dc_wr_rdy) begin
          chk("en_exclusive", bus.mem_rd_en & bus.mem_wr_en, 0);
          chk("rdy_exclusive", bus.dc_rd_rdy & bus.dc_wr_rdy, 0);
          chk("rdy_with_en", {bus.dc_rd_rdy & ~bus.mem_rd_en, bus.dc_wr_rdy & ~bus.mem_wr_en}, 0);
          chk("one_outstanding", (busy || cyc <= free_cyc), 0);
          busy = 1'b1;
          if (gnt_q.size() == 0) begin
            chk("grant_unexpected", 1, 0);
          end else begin
            g = gnt_q.pop_front();
            kind_obs = bus.mem_wr_en ? K_WR : (bus.dc_rd_rdy ? K_DR : K_IR);
            chk("grant_kind", kind_obs, g.kind);
            if (g.kind == K_WR) begin
              chk("wr_addr", bus.mem_wr_addr, g.addr);
              chk("wr_strb_data", {bus.mem_wstrb, bus.mem_wr_data}, {g.strb, g.data});
            end else begin
              chk("rd_addr", bus.mem_rd_addr, g.addr);
            end
          end
        end
        if (bus.ic_ret_valid) begin
          chk("ic_ret_latency", cyc, last_valid_cyc + 1);
          if (ic_q.size() == 0) chk("ic_ret_unexpected", 1, 0);
          else chk("ic_ret_data", bus.ic_ret_data, ic_q.pop_front());
        end
        if (bus.dc_ret_valid) begin
          chk("dc_ret_latency", cyc, last_valid_cyc + 1);
          if (dc_q.size() == 0) chk("dc_ret_unexpected", 1, 0);
          else chk("dc_ret_data", bus.dc_ret_data, dc_q.pop_front());
        end
      end

      bus.mem_rd_valid = 1'b0;
      bus.mem_wr_ack   = 1'b0;
      if (rst) begin
        busy   = 1'b0;
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (bus.mem_wr_en) begin
          wr_cnt = wr_delay;
        end else if (wr_cnt > 0) begin
          wr_cnt--;
          if (wr_cnt == 0) begin
            bus.mem_wr_ack = 1'b1;
            busy = 1'b0;
            free_cyc = cyc;
          end
        end
        if (bus.mem_rd_en && rd_resp_en) begin
          rd_cnt = rd_delay;
          rd_addr_m = bus.mem_rd_addr;
        end else if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = mem_line(rd_addr_m);
            busy = 1'b0;
            free_cyc = cyc + 1;
            last_valid_cyc = cyc;
          end
        end
        if (cyc == inject_cyc) begin
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data  = {32{8'h55}};
        end
      end
    end
  end

  task automatic do_dc_read(input logic [31:0] a);
    bit ok = 1'b0;
    bus.dc_rd_addr = a;
    bus.dc_rd_req  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.dc_rd_rdy) begin ok = 1'b1; break; end
    end
    chk("dc_rd_accept", ok, 1);
    @(posedge clk); #1;
    bus.dc_rd_req = 1'b0;
  endtask

  task automatic do_dc_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bit ok = 1'b0;
    bus.dc_wr_addr  = a;
    bus.dc_wr_wstrb = s;
    bus.dc_wr_data  = d;
    bus.dc_wr_req   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.dc_wr_rdy) begin ok = 1'b1; break; end
    end
    chk("dc_wr_accept", ok, 1);
    @(posedge clk); #1;
    bus.dc_wr_req = 1'b0;
  endtask

  task automatic do_ic_read(input logic [31:0] a);
    bit ok = 1'b0;
    bus.ic_rd_addr = a;
    bus.ic_rd_req  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.ic_ret_valid) begin ok = 1'b1; break; end
    end
    chk("ic_rd_done", ok, 1);
    @(posedge clk); #1;
    bus.ic_rd_req = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (gnt_q.size() == 0 && ic_q.size() == 0 && dc_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", ok, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_ctrl"}, {bus.ic_ret_valid, bus.dc_ret_valid, bus.dc_rd_rdy, bus.dc_wr_rdy,
                         bus.mem_rd_en, bus.mem_wr_en}, 0);
    chk({pfx, "_addr"}, {bus.mem_rd_addr, bus.mem_wr_addr}, 0);
    chk({pfx, "_wdata"}, {bus.mem_wstrb, bus.mem_wr_data}, 0);
    chk({pfx, "_ic_data"}, bus.ic_ret_data, 0);
    chk({pfx, "_dc_data"}, bus.dc_ret_data, 0);
  endtask

  initial begin : main
    bit ok;
    rst = 1'b1;
    rd_delay = 2;
    wr_delay = 2;
    rd_resp_en = 1'b1;
    inject_cyc = -1;
    bus.ic_rd_req = 1'b0;  bus.ic_rd_addr = 32'd0;
    bus.dc_rd_req = 1'b0;  bus.dc_rd_addr = 32'd0;
    bus.dc_wr_req = 1'b0;  bus.dc_wr_addr = 32'd0;
    bus.dc_wr_wstrb = 4'd0; bus.dc_wr_data = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // dcache line read, memory answers two cycles after the strobe
    gnt_q.push_back(mk(K_DR, 32'h1C00_0040, 4'd0, 32'd0));
    dc_q.push_back({32{8'hAA}});
    do_dc_read(32'h1C00_0040);
    drain();
    chk("dc_ret_hold", bus.dc_ret_data, {32{8'hAA}});

    // write with slow ack, then a read that must wait for it
    wr_delay = 5;
    gnt_q.push_back(mk(K_WR, 32'h0000_1000, 4'b0011, 32'hDEAD_BEEF));
    gnt_q.push_back(mk(K_DR, 32'h0000_2040, 4'd0, 32'd0));
    dc_q.push_back(mem_line(32'h0000_2040));
    do_dc_write(32'h0000_1000, 4'b0011, 32'hDEAD_BEEF);
    do_dc_read(32'h0000_2040);
    drain();
    wr_delay = 2;

    // all three at once: write, then dcache read, then icache
    gnt_q.push_back(mk(K_WR, 32'h0000_3000, 4'b1111, 32'h1234_5678));
    gnt_q.push_back(mk(K_DR, 32'h0000_4000, 4'd0, 32'd0));
    gnt_q.push_back(mk(K_IR, 32'h0000_5000, 4'd0, 32'd0));
    dc_q.push_back(mem_line(32'h0000_4000));
    ic_q.push_back(mem_line(32'h0000_5000));
    fork
      do_dc_write(32'h0000_3000, 4'b1111, 32'h1234_5678);
      do_dc_read(32'h0000_4000);
      do_ic_read(32'h0000_5000);
    join
    drain();

    // starvation: four dcache grants, then the icache is forced in
    for (int i = 0; i < 4; i++) begin
      gnt_q.push_back(mk(K_DR, 32'h0000_6000 + 32'(i * 32), 4'd0, 32'd0));
      dc_q.push_back(mem_line(32'h0000_6000 + 32'(i * 32)));
    end
    gnt_q.push_back(mk(K_IR, 32'h0000_7000, 4'd0, 32'd0));
    ic_q.push_back(mem_line(32'h0000_7000));
    gnt_q.push_back(mk(K_DR, 32'h0000_6080, 4'd0, 32'd0));
    dc_q.push_back(mem_line(32'h0000_6080));
    fork
      do_ic_read(32'h0000_7000);
      begin
        for (int i = 0; i < 5; i++) do_dc_read(32'h0000_6000 + 32'(i * 32));
      end
    join
    drain();

    // icache flush while its read is in flight
    rd_delay = 4;
    gnt_q.push_back(mk(K_IR, 32'h0000_8000, 4'd0, 32'd0));
    bus.ic_rd_addr = 32'h0000_8000;
    bus.ic_rd_req  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.mem_rd_en) begin ok = 1'b1; break; end
    end
    chk("ic_flush_grant", ok, 1);
    @(posedge clk); #1;
    bus.ic_rd_req = 1'b0;
    drain();
    chk("ic_ret_hold", bus.ic_ret_data, mem_line(32'h0000_7000));
    rd_delay = 2;
    gnt_q.push_back(mk(K_DR, 32'h0000_9000, 4'd0, 32'd0));
    dc_q.push_back(mem_line(32'h0000_9000));
    do_dc_read(32'h0000_9000);
    drain();

    // reset during DRD_WAIT, stale memory data after release
    rd_resp_en = 1'b0;
    gnt_q.push_back(mk(K_DR, 32'h0000_A000, 4'd0, 32'd0));
    do_dc_read(32'h0000_A000);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    inject_cyc = cyc + 2;
    rd_resp_en = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_zero("post_rst");
    @(posedge clk); #1;
    gnt_q.push_back(mk(K_DR, 32'h0000_B000, 4'd0, 32'd0));
    dc_q.push_back(mem_line(32'h0000_B000));
    do_dc_read(32'h0000_B000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
